lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Multi-cycle load/store unit, directly downstream of exe. Takes exe's address result plus decoded
//  load/store info; issues one access on a valid/ready data-memory port; returns aligned, extended
//  load data and rd to the register write-back. busy_o stalls pcReg/ifu while an access is in flight.
// PARAMETERS
//  XLEN    32  data/register width
//  ADDR_W  32  memory address width
// PORTS
//  clk_i             in   1       core clock, single clock domain
//  rst_i             in   1       synchronous, active-high reset
//  valid_i           in   1       exe result valid this cycle
//  load_i            in   5       one-hot {lhu,lbu,lw,lh,lb}; all-zero = not a load
//  store_i           in   3       one-hot {sw,sh,sb}; all-zero = not a store
//  addr_i            in   ADDR_W  effective address (exe res)
//  wdata_i           in   XLEN    store data (src2)
//  rd_i              in   5       load destination register
//  in_ready_o        out  1       lsu can accept (state==IDLE)
//  busy_o            out  1       access in flight (state!=IDLE)
//  mem_req_valid_o   out  1       request valid
//  mem_req_ready_i   in   1       memory accepts request
//  mem_req_addr_o    out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
//  mem_req_wen_o     out  1       1 = write
//  mem_req_wdata_o   out  XLEN    lane-shifted store data
//  mem_req_wmask_o   out  4       byte-enable mask
//  mem_resp_valid_i  in   1       response (load data or write ack) valid
//  mem_resp_rdata_i  in   XLEN    raw read word
//  wb_valid_o        out  1       one-cycle completion pulse
//  wb_wen_o          out  1       write rd (loads only, rd!=0)
//  wb_rd_o           out  5       destination register
//  wb_rdata_o        out  XLEN    extended load data
//  misalign_o        out  1       misaligned-access flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 except in_ready_o=1; latched request regs cleared.
//  - FSM IDLE->REQ->WAIT->DONE->IDLE.
//  - IDLE: accept when valid_i && (load_i!=0 || store_i!=0); latch addr/wdata/rd/type; ->REQ.
//    Both load_i and store_i nonzero: load wins. valid_i with neither: ignored, stays IDLE.
//  - REQ: mem_req_valid_o=1, addr/wen/wdata/wmask held stable until mem_req_ready_i; on handshake ->WAIT.
//  - WAIT: on mem_resp_valid_i latch rdata ->DONE. mem_resp_valid_i outside WAIT is ignored
//    (response never in same cycle as request handshake).
//  - DONE: wb_valid_o=1 one cycle, wb_wen_o=load&&rd!=0; ->IDLE. Min latency accept->wb_valid_o = 3 cycles
//    with ready_i=1 and resp one cycle after handshake.
//  - Store lane: off=addr[1:0]; sb mask 4'b0001<<off, sh 4'b0011<<off, sw 4'b1111;
//    wdata = wdata_i << (8*off). Loads: wen=0, wmask=0.
//  - Load extract: w = rdata >> (8*off); lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw = w.
//  - wb_rdata_o=0 for stores. Outputs hold only in DONE; 0 elsewhere.
//  - rst_i mid-access: immediate return to IDLE, request dropped, no wb_valid_o; memory tolerates abandoned req.
// CONFIGURATION
//  - LSU_MISALIGN_CHK_EN defined: lh/lhu/sh with addr[0]=1, lw/sw with addr[1:0]!=0 skip REQ/WAIT,
//    go IDLE->DONE; DONE asserts wb_valid_o=1, misalign_o=1, wb_wen_o=0, wb_rdata_o=0; no memory traffic.
//  - Undefined: misalign_o tied 0; misaligned access issued as-is (bytes past lane 3 dropped; masks truncate to 4 bits).
// STRUCTURE
//  - Shared defines file: load/store one-hot bus widths and bit positions (`ysyx_23060251_load_bus,
//    `ysyx_23060251_store_bus), FSM state encodings, XLEN.
//  - Sub-module lsu_align: combinational store mask/data shift and load extract/extend; lsu holds FSM + regs.
//  - top: exe res -> addr_i; wb mux selects lsu data when wb_valid_o; busy_o gates pc update.
// TESTING
//  1 lw addr=0x8000_0004, ready=1, resp 1 cycle later rdata=0xDEAD_BEEF, rd=5 -> wb_valid_o 3 cycles after accept, wb_rdata_o=0xDEADBEEF, wb_wen_o=1.
//  2 lb addr=...03, rdata=0x80FF_0000 -> wb_rdata_o=0xFFFF_FF80; lbu same -> 0x0000_0080; lh off 2 -> 0xFFFF_80FF.
//  3 sb addr=...02, wdata=0x0000_00AB -> wmask=4'b0100, wdata_o=0x00AB_0000, wen=1; wb_wen_o=0 on ack.
//  4 mem_req_ready_i low 4 cycles -> req fields stable, busy_o=1, in_ready_o=0 throughout; single handshake.
//  5 rst_i pulsed during WAIT -> next cycle IDLE, in_ready_o=1, no wb_valid_o; later access completes normally.
//  6 LSU_MISALIGN_CHK_EN: lw addr=...02 -> no mem_req_valid_o, wb_valid_o=1 & misalign_o=1 after 1 cycle, wb_wen_o=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: one-hot load/store bit positions,
// FSM encoding and the misalignment predicate used when LSU_MISALIGN_CHK_EN is defined.
package lsu_pkg;

  localparam int LSU_XLEN = 32;
  localparam int LD_W     = 5;
  localparam int ST_W     = 3;

  // load_i = {lhu,lbu,lw,lh,lb}, store_i = {sw,sh,sb}
  localparam int LD_LB  = 0;
  localparam int LD_LH  = 1;
  localparam int LD_LW  = 2;
  localparam int LD_LBU = 3;
  localparam int LD_LHU = 4;
  localparam int ST_SB  = 0;
  localparam int ST_SH  = 1;
  localparam int ST_SW  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  function automatic logic misaligned(input logic [LD_W-1:0] ld,
                                      input logic [ST_W-1:0] st,
                                      input logic [1:0]      off);
    logic half, word;
    half = ld[LD_LH] | ld[LD_LHU] | st[ST_SH];
    word = ld[LD_LW] | st[ST_SW];
    return (half & off[0]) | (word & (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte-mask/data shift and load extract with
// sign/zero extension. Lanes past byte 3 are dropped.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) (
  input  logic [LD_W-1:0] load_i,
  input  logic [ST_W-1:0] store_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      wmask_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [4:0]      sh;
  logic [XLEN-1:0] w;

  always_comb begin
    sh      = {off_i, 3'b000};
    w       = rdata_i >> sh;
    wmask_o = 4'b0000;
    wdata_o = '0;
    rdata_o = '0;

    if (|store_i) wdata_o = wdata_i << sh;
    if (store_i[ST_SB])      wmask_o = 4'b0001 << off_i;
    else if (store_i[ST_SH]) wmask_o = 4'b0011 << off_i;
    else if (store_i[ST_SW]) wmask_o = 4'b1111;

    if (load_i[LD_LB])       rdata_o = {{(XLEN-8){w[7]}}, w[7:0]};
    else if (load_i[LD_LH])  rdata_o = {{(XLEN-16){w[15]}}, w[15:0]};
    else if (load_i[LD_LW])  rdata_o = w;
    else if (load_i[LD_LBU]) rdata_o = {{(XLEN-8){1'b0}}, w[7:0]};
    else if (load_i[LD_LHU]) rdata_o = {{(XLEN-16){1'b0}}, w[15:0]};
  end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: IDLE->REQ->WAIT->DONE FSM with one outstanding access.
// Optional macro LSU_MISALIGN_CHK_EN traps misaligned half/word accesses without memory traffic.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN   = LSU_XLEN,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [LD_W-1:0]   load_i,
  input  logic [ST_W-1:0]   store_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [4:0]        rd_i,
  output logic              in_ready_o,
  output logic              busy_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic              mem_req_wen_o,
  output logic [XLEN-1:0]   mem_req_wdata_o,
  output logic [3:0]        mem_req_wmask_o,
  input  logic              mem_resp_valid_i,
  input  logic [XLEN-1:0]   mem_resp_rdata_i,
  output logic              wb_valid_o,
  output logic              wb_wen_o,
  output logic [4:0]        wb_rd_o,
  output logic [XLEN-1:0]   wb_rdata_o,
  output logic              misalign_o
);

  lsu_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q, wb_rdata_q;
  logic [4:0]        rd_q, wb_rd_q;
  logic [LD_W-1:0]   load_q, ld_d;
  logic [ST_W-1:0]   store_q, st_d;
  logic              req_valid_q, wb_valid_q, wb_wen_q, misalign_q;
  logic              accept_d, mis_d;
  logic [3:0]        al_wmask;
  logic [XLEN-1:0]   al_wdata, al_rdata;

  // Load takes precedence when both one-hot buses are set.
  always_comb begin
    ld_d     = load_i;
    st_d     = (|load_i) ? '0 : store_i;
    accept_d = valid_i && ((|load_i) || (|store_i)) && (state_q == S_IDLE);
`ifdef LSU_MISALIGN_CHK_EN
    mis_d    = misaligned(ld_d, st_d, addr_i[1:0]);
`else
    mis_d    = 1'b0;
`endif
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .load_i  (load_q),
    .store_i (store_q),
    .off_i   (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (mem_resp_rdata_i),
    .wmask_o (al_wmask),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      load_q      <= '0;
      store_q     <= '0;
      req_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_wen_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_rdata_q  <= '0;
      misalign_q  <= 1'b0;
    end else begin
      // Write-back outputs live for exactly the DONE cycle.
      wb_valid_q <= 1'b0;
      wb_wen_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_rdata_q <= '0;
      misalign_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (accept_d) begin
          addr_q  <= addr_i;
          wdata_q <= wdata_i;
          rd_q    <= rd_i;
          load_q  <= ld_d;
          store_q <= st_d;
          if (mis_d) begin
            state_q    <= S_DONE;
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_i;
            misalign_q <= 1'b1;
          end else begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b1;
          end
        end
        S_REQ: if (mem_req_ready_i) begin
          req_valid_q <= 1'b0;
          state_q     <= S_WAIT;
        end
        S_WAIT: if (mem_resp_valid_i) begin
          state_q    <= S_DONE;
          wb_valid_q <= 1'b1;
          wb_wen_q   <= (|load_q) && (rd_q != 5'd0);
          wb_rd_q    <= rd_q;
          wb_rdata_q <= al_rdata;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o      = (state_q == S_IDLE);
  assign busy_o          = (state_q != S_IDLE);
  assign mem_req_valid_o = req_valid_q;
  assign mem_req_addr_o  = req_valid_q ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_req_wen_o   = req_valid_q && (|store_q);
  assign mem_req_wdata_o = req_valid_q ? al_wdata : '0;
  assign mem_req_wmask_o = req_valid_q ? al_wmask : 4'b0000;
  assign wb_valid_o      = wb_valid_q;
  assign wb_wen_o        = wb_wen_q;
  assign wb_rd_o         = wb_rd_q;
  assign wb_rdata_o      = wb_rdata_q;
  assign misalign_o      = misalign_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a byte-level reference memory predicts requests and write-backs,
// a responder models data memory, and a monitor compares everything the DUT presents.
module tb_lsu;
  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, mem_req_ready_i, mem_resp_valid_i;
  logic [4:0]  load_i, rd_i, wb_rd_o;
  logic [2:0]  store_i;
  logic [31:0] addr_i, wdata_i, mem_req_addr_o, mem_req_wdata_o, mem_resp_rdata_i, wb_rdata_o;
  logic        in_ready_o, busy_o, mem_req_valid_o, mem_req_wen_o, wb_valid_o, wb_wen_o, misalign_o;
  logic [3:0]  mem_req_wmask_o;

  lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .load_i(load_i), .store_i(store_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i), .in_ready_o(in_ready_o), .busy_o(busy_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_wen_o(mem_req_wen_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wmask_o(mem_req_wmask_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_rdata_i(mem_resp_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_wen_o(wb_wen_o), .wb_rd_o(wb_rd_o), .wb_rdata_o(wb_rdata_o),
    .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] wmask; } req_t;
  typedef struct { logic wen; logic [4:0] rd; logic [31:0] rdata; logic mis; } wb_t;

  req_t        exp_req[$];
  wb_t         exp_wb[$];
  logic [7:0]  ref_mem [64];
  logic [31:0] dut_mem [16];
  int          n_vec = 0, n_err = 0, n_hs = 0;
  bit          fast = 1'b0;
  int          hold_ready = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void poke(input int w, input logic [31:0] v);
    dut_mem[w] = v;
    for (int b = 0; b < 4; b++) ref_mem[w*4+b] = v[8*b +: 8];
  endfunction

  // Reference: access size/sign from the one-hot type, bytes taken lane by lane.
  function automatic void model(input logic [4:0] ld, input logic [2:0] st, input logic [31:0] a,
                                input logic [31:0] wd, input logic [4:0] rd);
    int off, sz, base; bit is_ld, sgn; logic [31:0] v; req_t r; wb_t w;
    is_ld = (ld != 0);
    off   = int'(a[1:0]);
    base  = int'(a[5:2]) * 4;
    if (is_ld) begin
      sz  = (ld[0] || ld[3]) ? 1 : (ld[1] || ld[4]) ? 2 : 4;
      sgn = ld[0] || ld[1];
    end else begin
      sz  = st[0] ? 1 : st[1] ? 2 : 4;
      sgn = 1'b0;
    end
    w.rd = rd;
`ifdef LSU_MISALIGN_CHK_EN
    if (off % sz != 0) begin
      w.wen = 1'b0; w.rdata = 32'd0; w.mis = 1'b1;
      exp_wb.push_back(w);
      return;
    end
`endif
    r.addr = {a[31:2], 2'b00}; r.wen = !is_ld; r.wdata = 32'd0; r.wmask = 4'd0; v = 32'd0;
    if (is_ld) begin
      for (int i = 0; i < sz; i++) if (off + i < 4) v[8*i +: 8] = ref_mem[base+off+i];
      if (sgn && v[8*sz-1]) for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end else begin
      for (int l = 0; l < 4; l++) if (l >= off) r.wdata[8*l +: 8] = wd[8*(l-off) +: 8];
      for (int l = 0; l < 4; l++)
        if (st[2] || (l >= off && l < off + sz)) begin
          r.wmask[l] = 1'b1;
          ref_mem[base+l] = r.wdata[8*l +: 8];
        end
    end
    exp_req.push_back(r);
    w.wen = is_ld && (rd != 0); w.rdata = v; w.mis = 1'b0;
    exp_wb.push_back(w);
  endfunction

  // Data memory responder: applies writes on handshake, answers after 0..2 extra cycles.
  initial begin
    bit hs, pend, we; int dly; logic [31:0] a, pa, d; logic [3:0] m;
    pend = 0; dly = 0; pa = 0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_rdata_i = 32'd0;
    forever begin
      @(negedge clk_i);
      hs = mem_req_valid_o && mem_req_ready_i;
      a = mem_req_addr_o; d = mem_req_wdata_o; m = mem_req_wmask_o; we = mem_req_wen_o;
      if (rst_i) pend = 0;
      @(posedge clk_i); #2;
      mem_resp_valid_i = 1'b0;
      mem_resp_rdata_i = $urandom;
      if (hs) begin
        if (we) for (int l = 0; l < 4; l++) if (m[l]) dut_mem[a[5:2]][8*l +: 8] = d[8*l +: 8];
        pend = 1; pa = a; dly = fast ? 0 : int'($urandom_range(0, 2));
      end
      if (pend) begin
        if (dly == 0) begin
          mem_resp_valid_i = 1'b1;
          mem_resp_rdata_i = dut_mem[pa[5:2]];
          pend = 0;
        end else dly--;
      end else if (!busy_o && $urandom_range(0, 3) == 0) mem_resp_valid_i = 1'b1;
      if (hold_ready > 0) begin mem_req_ready_i = 1'b0; hold_ready--; end
      else mem_req_ready_i = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: compares requests on handshake and write-backs on wb_valid_o.
  initial begin
    logic pv, pr, pw; logic [31:0] pa, pd; logic [3:0] pm; req_t r; wb_t w;
    pv = 0; pr = 0; pw = 0; pa = 0; pd = 0; pm = 0;
    forever begin
      @(negedge clk_i);
      if (pv && !pr && !rst_i) begin
        check("req_hold_addr", {31'd0, mem_req_valid_o, mem_req_addr_o}, {31'd0, 1'b1, pa});
        check("req_hold_data", {mem_req_wen_o, mem_req_wmask_o, mem_req_wdata_o}, {pw, pm, pd});
      end
      if (mem_req_valid_o) check("req_busy", {in_ready_o, busy_o}, 2'b01);
      if (mem_req_valid_o && mem_req_ready_i) begin
        n_hs++;
        if (exp_req.size() == 0) check("unexpected_req", 1, 0);
        else begin
          r = exp_req.pop_front();
          check("req_addr", mem_req_addr_o, r.addr);
          check("req_wen", mem_req_wen_o, r.wen);
          check("req_wmask", mem_req_wmask_o, r.wmask);
          if (r.wen) check("req_wdata", mem_req_wdata_o, r.wdata);
        end
      end
      if (wb_valid_o) begin
        if (exp_wb.size() == 0) check("unexpected_wb", 1, 0);
        else begin
          w = exp_wb.pop_front();
          check("wb_wen", wb_wen_o, w.wen);
          check("wb_rd", wb_rd_o, w.rd);
          check("wb_rdata", wb_rdata_o, w.rdata);
          check("wb_misalign", misalign_o, w.mis);
        end
      end else check("wb_quiet", {wb_wen_o, wb_rd_o, wb_rdata_o, misalign_o}, 64'd0);
      pv = mem_req_valid_o; pr = mem_req_ready_i; pa = mem_req_addr_o;
      pd = mem_req_wdata_o; pm = mem_req_wmask_o; pw = mem_req_wen_o;
    end
  end

  task automatic issue(input logic [4:0] ld, input logic [2:0] st, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    int t;
    @(posedge clk_i); #2;
    valid_i = 1'b1; load_i = ld; store_i = st; addr_i = a; wdata_i = wd; rd_i = rd;
    t = 0;
    forever begin
      @(negedge clk_i);
      if (in_ready_o) break;
      if (++t > 100) begin check("accept_timeout", 1, 0); break; end
    end
    if (in_ready_o && (ld != 0 || st != 0)) model(ld, st, a, wd, rd);
    @(posedge clk_i); #2;
    valid_i = 1'b0; load_i = $urandom; store_i = $urandom; addr_i = $urandom; rd_i = $urandom;
  endtask

  task automatic wait_wb(output int n);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!wb_valid_o && n < 60);
    if (!wb_valid_o) check("wb_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_wb.size() != 0 || !in_ready_o) && t < 300) begin @(negedge clk_i); t++; end
    if (t >= 300) check("drain_timeout", exp_wb.size(), 0);
  endtask

  initial begin
    int n, hs0, k; logic [4:0] ld; logic [2:0] st;
    rst_i = 1'b1; valid_i = 1'b0; load_i = 0; store_i = 0; addr_i = 0; wdata_i = 0; rd_i = 0;
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_ready", {in_ready_o, busy_o, mem_req_valid_o, wb_valid_o, misalign_o}, 5'b10000);
    check("reset_outs", {mem_req_addr_o, mem_req_wdata_o}, 64'd0);
    @(posedge clk_i); #2; rst_i = 1'b0;

    fast = 1'b1;
    poke(1, 32'hDEAD_BEEF);
    issue(5'b00100, 3'b000, 32'h8000_0004, 32'd0, 5'd5);
    wait_wb(n);
    check("t1_latency", n, 3);
    check("t1_data", {wb_wen_o, wb_rdata_o}, {1'b1, 32'hDEAD_BEEF});

    poke(0, 32'h80FF_0000);
    issue(5'b00001, 3'b000, 32'h8000_0003, 32'd0, 5'd6); wait_wb(n);
    check("t2_lb", wb_rdata_o, 32'hFFFF_FF80);
    issue(5'b01000, 3'b000, 32'h8000_0003, 32'd0, 5'd6); wait_wb(n);
    check("t2_lbu", wb_rdata_o, 32'h0000_0080);
    issue(5'b00010, 3'b000, 32'h8000_0002, 32'd0, 5'd6); wait_wb(n);
    check("t2_lh", wb_rdata_o, 32'hFFFF_80FF);

    issue(5'b00000, 3'b001, 32'h8000_0002, 32'h0000_00AB, 5'd7);
    @(negedge clk_i);
    check("t3_req", {mem_req_wen_o, mem_req_wmask_o, mem_req_wdata_o}, {1'b1, 4'b0100, 32'h00AB_0000});
    wait_wb(n);
    check("t3_wb_wen", wb_wen_o, 1'b0);
    wait_idle();

    hs0 = n_hs; hold_ready = 6;
    issue(5'b00000, 3'b100, 32'h8000_0008, 32'h1234_5678, 5'd3);
    wait_wb(n); wait_idle();
    check("t4_one_hs", n_hs - hs0, 1);

    fast = 1'b0;
    issue(5'b00100, 3'b000, 32'h8000_0010, 32'd0, 5'd9);
    k = 0;
    do begin @(negedge clk_i); k++; end while (!(mem_req_valid_o && mem_req_ready_i) && k < 60);
    @(posedge clk_i); #2; rst_i = 1'b1;
    void'(exp_wb.pop_back());
    @(negedge clk_i);
    check("t5_no_wb", wb_valid_o, 1'b0);
    @(posedge clk_i); #2; rst_i = 1'b0;
    @(negedge clk_i);
    check("t5_idle", {in_ready_o, busy_o, wb_valid_o}, 3'b100);
    issue(5'b00100, 3'b000, 32'h8000_0014, 32'd0, 5'd10);
    wait_wb(n); wait_idle();

`ifdef LSU_MISALIGN_CHK_EN
    hs0 = n_hs;
    issue(5'b00100, 3'b000, 32'h8000_0002, 32'd0, 5'd11);
    wait_wb(n);
    check("t6_latency", n, 1);
    check("t6_flags", {misalign_o, wb_wen_o}, 2'b10);
    wait_idle();
    check("t6_no_traffic", n_hs - hs0, 0);
`endif

    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 9));
      ld = 0; st = 0;
      if (k < 5) ld = 5'd1 << k;
      else if (k < 8) st = 3'd1 << (k - 5);
      else if (k == 8) begin ld = 5'd1 << $urandom_range(0, 4); st = 3'd1 << $urandom_range(0, 2); end
      issue(ld, st, 32'h8000_0000 | 32'($urandom_range(0, 63)), $urandom, 5'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
    end
    wait_idle();
    check("drain_req", exp_req.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
